// File: rtl/alu_seq.sv
// Multi-cycle RV32 ALU: single-cycle RV32I ops, iterative RV32M mul/div/rem (DATA_WIDTH cycles).
// Optional ALU_ERR_EN macro adds err_o, flagging div/rem by zero and unsupported opcode/funct.
module alu_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [2:0]              funct3_i,
  input  logic [6:0]              funct7_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    is_zero_o,
  output logic                    is_less_o,
  output logic                    is_less_u_o
`ifdef ALU_ERR_EN
  ,
  output logic                    err_o
`endif
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  // RV32 base opcode map
  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_LOAD      = OPCODE_WIDTH'(7'b0000011),
    OP_IMMEDIATE = OPCODE_WIDTH'(7'b0010011),
    OP_STORE     = OPCODE_WIDTH'(7'b0100011),
    OP_R         = OPCODE_WIDTH'(7'b0110011),
    OP_JAL       = OPCODE_WIDTH'(7'b1101111)
  } opcode_e;

  typedef enum logic {IDLE, CALC} state_e;

  state_e          state;
  logic [SW-1:0]   cnt;
  logic [2*W-1:0]  acc;      // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [W-1:0]    opnd;     // multiplicand or divisor magnitude
  logic [2:0]      f3_q;
  logic            neg_q;
  logic            neg_rem_q;
  logic            div0_q;

  logic            accept;
  logic            is_r;
  logic            is_m;
  logic            lt_s;
  logic            lt_u;
  logic [SW-1:0]   shamt;
  logic [W-1:0]    alu_res;

  assign accept = start_i & ~busy_o;
  assign is_r   = (opcode_i == OP_R);
  assign is_m   = is_r & (funct7_i == 7'b0000001);
  assign lt_s   = $signed(a_i) < $signed(b_i);
  assign lt_u   = a_i < b_i;
  assign shamt  = b_i[SW-1:0];

  // Single-cycle result, computed from the live inputs and registered at accept.
  always_comb begin
    // NOTE: default first so every path assigns alu_res and no latch is inferred.
    alu_res = '0;
    if (is_r || opcode_i == OP_IMMEDIATE) begin
      case (funct3_i)
        3'b000:  alu_res = (is_r && funct7_i[5]) ? a_i - b_i : a_i + b_i;
        3'b001:  alu_res = a_i << shamt;
        3'b010:  alu_res = {{(W-1){1'b0}}, lt_s};
        3'b011:  alu_res = {{(W-1){1'b0}}, lt_u};
        3'b100:  alu_res = a_i ^ b_i;
        3'b101:  alu_res = funct7_i[5] ? W'($signed(a_i) >>> shamt) : a_i >> shamt;
        3'b110:  alu_res = a_i | b_i;
        default: alu_res = a_i & b_i;
      endcase
    end else if (opcode_i == OP_LOAD || opcode_i == OP_STORE || opcode_i == OP_JAL) begin
      alu_res = a_i + b_i;
    end
  end

  // Operand signedness for the M ops; the datapath works on magnitudes.
  logic         a_sgn;
  logic         b_sgn;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  assign a_sgn = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign b_sgn = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
  assign a_neg = a_sgn & a_i[W-1];
  assign b_neg = b_sgn & b_i[W-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // One shift-add or restoring-divide step.
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [W-1:0]   rem_nx;
  logic [2*W-1:0] acc_nx;

  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign rem_nx    = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
  assign acc_nx    = f3_q[2] ? {rem_nx, acc[W-2:0], div_ge} : {mul_sum, acc[W-1:1]};

  // Sign fix on the final step. A zero divisor already yields rem = |a| (restored to a
  // by neg_rem_q); only the quotient needs forcing to all ones.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   m_res;

  always_comb begin
    prod_fix = neg_q ? -acc_nx : acc_nx;
    quo_fix  = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem_fix  = neg_rem_q ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    case (f3_q)
      3'b000:                 m_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: m_res = prod_fix[2*W-1:W];
      3'b100, 3'b101:         m_res = div0_q ? '1 : quo_fix;
      default:                m_res = rem_fix;
    endcase
  end

`ifdef ALU_ERR_EN
  logic unsupported;

  always_comb begin
    unsupported = 1'b0;
    if (is_r) begin
      unsupported = !((funct7_i == 7'b0000000) || (funct7_i == 7'b0000001) ||
                      ((funct7_i == 7'b0100000) && (funct3_i == 3'b000 || funct3_i == 3'b101)));
    end else if (opcode_i == OP_IMMEDIATE) begin
      if (funct3_i == 3'b001)
        unsupported = (funct7_i != 7'b0000000);
      else if (funct3_i == 3'b101)
        unsupported = (funct7_i != 7'b0000000) && (funct7_i != 7'b0100000);
    end else if (opcode_i != OP_LOAD && opcode_i != OP_STORE && opcode_i != OP_JAL) begin
      unsupported = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= '0;
      is_zero_o   <= 1'b0;
      is_less_o   <= 1'b0;
      is_less_u_o <= 1'b0;
`ifdef ALU_ERR_EN
      err_o       <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef ALU_ERR_EN
      err_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            is_zero_o   <= (a_i == b_i);
            is_less_o   <= lt_s;
            is_less_u_o <= lt_u;
            if (is_m) begin
              state     <= CALC;
              busy_o    <= 1'b1;
              cnt       <= '0;
              f3_q      <= funct3_i;
              neg_q     <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              div0_q    <= funct3_i[2] & (b_i == '0);
              acc       <= {{W{1'b0}}, (funct3_i[2] ? a_mag : b_mag)};
              opnd      <= funct3_i[2] ? b_mag : a_mag;
            end else begin
              result_o <= alu_res;
              done_o   <= 1'b1;
`ifdef ALU_ERR_EN
              err_o    <= unsupported;
`endif
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(W - 1)) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= m_res;
`ifdef ALU_ERR_EN
            err_o    <= div0_q;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
